// File: rtl/seven_seg_scan.sv
// seven_seg_scan
//   Time-multiplexed driver for an eight-digit seven-segment display.
//   Each digit owns a slot of CLK_DIV clock cycles: the first BLANK_CYC
//   cycles are dead time (no anode, no segments) to avoid ghosting, the
//   rest light the current digit. New display values arrive through a
//   valid/ready handshake, wait in a pending register and are only
//   promoted to the display register at a frame boundary, so a frame
//   never shows a mix of old and new digits.
//
// Ports
//   clk         single clock, rising edge
//   rst         synchronous active-high reset
//   load_valid  new display value offered
//   load_data   eight hex nibbles, nibble k drives digit k
//   load_ready  a value can be accepted (no value pending, not in reset)
//   blank_lz    leading-zero blanking enable, sampled every cycle
//   seg         segment pattern, bit6=a .. bit0=g (registered)
//   an          one-hot digit enable, bit k = digit k (registered)
//   frame_done  one-cycle pulse after the last slot of a frame
module seven_seg_scan #(
  parameter int CLK_DIV    = 1000,
  parameter int BLANK_CYC  = 50,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  output logic        load_ready,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic [7:0]  an,
  output logic        frame_done
);

  localparam int TW = $clog2(CLK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] BLANK_END = TW'(BLANK_CYC);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_t;

  state_t        state_reg, state_next;
  logic [TW-1:0] tick_reg, tick_next;
  logic [2:0]    digit_reg, digit_next;
  logic [6:0]    seg_reg, seg_next;
  logic [7:0]    an_reg, an_next;
  logic          frame_done_reg;
  logic [31:0]   display_reg;
  logic [31:0]   pend_reg;
  logic          pending_reg;

  logic          boundary;
  logic          accept;
  logic [7:0]    lz_blank;
  logic [3:0]    nibble;

  // Active-high segment encoding, bit6=a .. bit0=g.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h7E;
      4'h1: s = 7'h30;
      4'h2: s = 7'h6D;
      4'h3: s = 7'h79;
      4'h4: s = 7'h33;
      4'h5: s = 7'h5B;
      4'h6: s = 7'h5F;
      4'h7: s = 7'h70;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h7B;
      4'hA: s = 7'h77;
      4'hB: s = 7'h1F;
      4'hC: s = 7'h4E;
      4'hD: s = 7'h3D;
      4'hE: s = 7'h4F;
      default: s = 7'h47;
    endcase
    return s;
  endfunction

  // Last tick of digit 7: the only place the display register may change.
  assign boundary   = (digit_reg == 3'd7) && (tick_reg == TICK_LAST);
  assign load_ready = !pending_reg && !rst;
  assign accept     = load_valid && load_ready;
  assign nibble     = display_reg[{digit_reg, 2'b00} +: 4];

  // Digit k is a leading zero when it and every higher nibble are zero.
  // Digit 0 is never blanked so a zero value still shows "0".
  assign lz_blank[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 8; gi++) begin : g_lz
      assign lz_blank[gi] = blank_lz & ~|display_reg[31:4*gi];
    end
  endgenerate

  // Scan FSM state register together with the slot counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_BLANK;
      tick_reg  <= '0;
      digit_reg <= '0;
      seg_reg   <= '0;
      an_reg    <= '0;
    end else begin
      state_reg <= state_next;
      tick_reg  <= tick_next;
      digit_reg <= digit_next;
      seg_reg   <= seg_next;
      an_reg    <= an_next;
    end
  end

  // Next slot position, next state, and pin values for the current state.
  // The state tracks the tick it is registered with, so the pin registers
  // lag the state by exactly one cycle.
  always_comb begin
    tick_next  = tick_reg + 1'b1;
    digit_next = digit_reg;
    seg_next   = '0;
    an_next    = '0;
    if (tick_reg == TICK_LAST) begin
      tick_next  = '0;
      digit_next = digit_reg + 3'd1;
    end
    state_next = (tick_next < BLANK_END) ? ST_BLANK : ST_ON;
    if (state_reg == ST_ON) begin
      an_next  = 8'b1 << digit_reg;
      seg_next = lz_blank[digit_reg] ? 7'h00 : hex_to_seg(nibble);
    end
  end

  // Load handshake and frame-synchronous display update.
  always_ff @(posedge clk) begin
    if (rst) begin
      display_reg    <= '0;
      pend_reg       <= '0;
      pending_reg    <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= boundary;
      if (boundary) begin
        if (pending_reg) begin
          display_reg <= pend_reg;
          pending_reg <= 1'b0;
        end else if (accept) begin
          // Arrived just in time: skip the pending stage entirely.
          display_reg <= load_data;
        end
      end else if (accept) begin
        pend_reg    <= load_data;
        pending_reg <= 1'b1;
      end
    end
  end

  assign seg        = ACTIVE_LOW ? ~seg_reg : seg_reg;
  assign an         = ACTIVE_LOW ? ~an_reg : an_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 SHALL have parameter CLK_DIV, default 1000, clock cycles per digit slot (legal range 2..65535).
REQ-002 SHALL have parameter BLANK_CYC, default 50, dead-time cycles at the start of each slot (legal range 1..CLK_DIV-1).
REQ-003 SHALL have parameter ACTIVE_LOW, default 1; when 1, seg and an outputs are inverted at the pins.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port load_valid, input, 1, new display value offered.
REQ-007 SHALL have port load_data, input, 32, eight hex nibbles; nibble k drives digit k.
REQ-008 SHALL have port load_ready, output, 1, controller can accept a value.
REQ-009 SHALL have port blank_lz, input, 1, leading-zero blanking enable, sampled every cycle.
REQ-010 SHALL have port seg, output, 7, segment pattern, bit6=a … bit0=g.
REQ-011 SHALL have port an, output, 8, one-hot digit enable; bit k = digit k.
REQ-012 SHALL have port frame_done, output, 1, one-cycle pulse at each frame boundary.

Function
REQ-013 SHALL keep a slot tick counter (0..CLK_DIV-1) and a 3-bit digit index; tick wraps to 0 and the digit index increments, 7 wrapping to 0.
REQ-014 SHALL run a two-state FSM per slot: BLANK for ticks 0..BLANK_CYC-1 (an all inactive, seg all inactive), then ON for ticks BLANK_CYC..CLK_DIV-1 (an one-hot on current digit).
REQ-015 SHALL encode nibbles in ON as 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B A=77 B=1F C=4E D=3D E=4F F=47 (active-high form).
REQ-016 SHALL register seg and an, so they reflect the state of the previous cycle (1-cycle latency from FSM state to pins).
REQ-017 SHALL accept a load on a cycle where load_valid and load_ready are both 1, storing it in a pending register and setting the pending flag.
REQ-018 SHALL drive load_ready = !pending flag and 0 while rst is high.
REQ-019 SHALL define the frame boundary as the cycle with digit index 7 and tick CLK_DIV-1; on that cycle, frame_done=1 (registered, visible the next cycle) and a pending value, if any, is copied to the display register and the pending flag is cleared.
REQ-020 SHALL, when a load is accepted on the boundary cycle with no pending value, copy load_data directly to the display register, leaving the pending flag clear.
REQ-021 SHALL never change the display register except at a frame boundary (no tearing within a frame).
REQ-022 SHALL, with blank_lz=1, force digit k (k≥1) to inactive seg (an still active) when all nibbles k..7 of the display register are zero; digit 0 SHALL always be shown.
REQ-023 SHALL hold load_valid/load_data stable-insensitive: a value is captured only on the handshake cycle.

Reset
REQ-024 SHALL, while rst=1, clear tick, digit index, pending flag, display and pending registers to 0, and drive an and seg inactive, frame_done=0, load_ready=0.
REQ-025 SHALL start the cycle after rst deasserts at digit 0, tick 0, state BLANK, with load_ready=1.
REQ-026 SHALL treat rst asserted mid-frame or mid-slot as a full reset, discarding any pending value.

Verification (CLK_DIV=4, BLANK_CYC=1, ACTIVE_LOW=0)
REQ-027 SHALL cover: release reset, no load -> an sequence 00,01,01,01,00,02,02,02,… with seg=7E during ON; frame_done every 32 cycles.
REQ-028 SHALL cover: load 0x12345678 at cycle 5 -> load_ready low until boundary; from the next frame digit0 seg=7F, digit7 seg=30; the current frame shows all 7E.
REQ-029 SHALL cover: second load_valid while pending -> not accepted (load_ready=0); the first value is displayed and the second is accepted once load_ready returns to 1.
REQ-030 SHALL cover: load 0x000000A0 with blank_lz=1 -> digit0 seg=7E, digit1 seg=77, digits 2..7 seg=00 with an still cycling; with blank_lz=0 -> digits 2..7 seg=7E.
REQ-031 SHALL cover: load accepted exactly on the boundary cycle -> that value is shown in the immediately following frame and load_ready stays 1.
REQ-032 SHALL cover: rst pulsed mid-frame with a pending value -> outputs inactive during reset; after release, display=0 and the pending value is lost.
